// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: operation and
// state encodings plus the step-counter width helper.
// Optional feature macro used by the unit: MULDIV_EARLY_EXIT_EN.
package muldiv_pkg;

   typedef enum logic [1:0] {
      MD_MULT  = 2'b00,
      MD_MULTU = 2'b01,
      MD_DIV   = 2'b10,
      MD_DIVU  = 2'b11
   } op_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_FIN  = 2'd2
   } state_t;

   // Step counter must be able to count up to WIDTH steps.
   function automatic int md_cnt_width(input int width);
      return $clog2(width + 1);
   endfunction

   localparam int MD_CNT_W_DEFAULT = $clog2(32 + 1);

   // Bit 1 of the encoding selects divide; bit 0 set means unsigned.
   function automatic logic op_is_div(input op_t op);
      return op[1];
   endfunction

   function automatic logic op_is_signed(input op_t op);
      return ~op[0];
   endfunction

endpackage

// File: rtl/alu_muldiv_if.sv
// Pipeline-facing bundle of the multiply/divide unit.
//
// Handshake: the pipeline raises start for one cycle while busy is low; the
// unit accepts it only in IDLE and when flush is low. busy is high from the
// cycle after acceptance until the cycle done pulses; done is a single-cycle
// pulse and hi/lo already hold the result in that cycle. A start seen while
// busy is dropped. flush aborts any operation in flight without a done.
interface alu_muldiv_if
   import muldiv_pkg::*;
#(
   parameter int WIDTH = 32
);
   logic             flush;
   logic             start;
   logic [1:0]       op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             hi_we;
   logic             lo_we;
   logic [WIDTH-1:0] wdata;
   logic             busy;
   logic             done;
   logic             div_by_zero;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;
   state_t           dbg_state;

   modport master (
      output flush, start, op, a, b, hi_we, lo_we, wdata,
      input  busy, done, div_by_zero, hi, lo, dbg_state
   );

   modport slave (
      input  flush, start, op, a, b, hi_we, lo_we, wdata,
      output busy, done, div_by_zero, hi, lo, dbg_state
   );
endinterface

// File: rtl/muldiv_step.sv
// One radix-2 iteration of the multiply/divide datapath.
// Multiply: acc += sh when the multiplier LSB is set, then sh <<= 1 and the
// multiplier (opd) >>= 1. Divide: restoring step on {remainder, quotient}
// held in acc, with opd as the divisor; sh passes through untouched.
module muldiv_step #(
   parameter int WIDTH = 32
) (
   input  logic               is_div,
   input  logic [2*WIDTH-1:0] acc_in,
   input  logic [2*WIDTH-1:0] sh_in,
   input  logic [WIDTH-1:0]   opd_in,
   output logic [2*WIDTH-1:0] acc_out,
   output logic [2*WIDTH-1:0] sh_out,
   output logic [WIDTH-1:0]   opd_out
);

   logic [WIDTH:0] rem_ext;
   logic [WIDTH:0] diff;

   // Single shift-add or restore-subtract step selected by is_div.
   always_comb begin
      acc_out = acc_in;
      sh_out  = sh_in;
      opd_out = opd_in;
      // Remainder shifted left with the next dividend bit pulled in.
      rem_ext = acc_in[2*WIDTH-1:WIDTH-1];
      diff    = rem_ext - {1'b0, opd_in};
      if (is_div) begin
         // rem_ext < 2*divisor, so a clear top bit means the subtract fits.
         if (!diff[WIDTH]) begin
            acc_out = {diff[WIDTH-1:0], acc_in[WIDTH-2:0], 1'b1};
         end else begin
            acc_out = {rem_ext[WIDTH-1:0], acc_in[WIDTH-2:0], 1'b0};
         end
      end else begin
         if (opd_in[0]) begin
            acc_out = acc_in + sh_in;
         end
         sh_out  = {sh_in[2*WIDTH-2:0], 1'b0};
         opd_out = {1'b0, opd_in[WIDTH-1:1]};
      end
   end

endmodule

// File: rtl/alu_muldiv.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning the HI/LO registers.
// Operands are converted to magnitudes at launch, iterated one bit per cycle
// in muldiv_step, and sign-corrected when written to HI/LO in FIN.
// Optional feature macro: MULDIV_EARLY_EXIT_EN (multiply leaves CALC as soon
// as the remaining multiplier bits are all zero).
module alu_muldiv
   import muldiv_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic        clk,
   input  logic        resetn,
   alu_muldiv_if.slave bus
);

   localparam int CW = md_cnt_width(WIDTH);

   state_t             state;
   state_t             state_nxt;
   logic [CW-1:0]      cnt;
   logic               is_div_q;
   logic               div0_q;
   logic               prod_neg_q;
   logic               rem_neg_q;
   logic [2*WIDTH-1:0] acc_q;
   logic [2*WIDTH-1:0] sh_q;
   logic [WIDTH-1:0]   opd_q;
   logic [2*WIDTH-1:0] acc_nx;
   logic [2*WIDTH-1:0] sh_nx;
   logic [WIDTH-1:0]   opd_nx;
   logic [WIDTH-1:0]   hi_q;
   logic [WIDTH-1:0]   lo_q;
   logic               done_q;
   logic               dbz_q;

   logic               launch;
   logic               step_en;
   logic               fin_commit;
   logic               calc_last;

   op_t                op_in;
   logic               a_neg;
   logic               b_neg;
   logic [WIDTH-1:0]   mag_a;
   logic [WIDTH-1:0]   mag_b;
   logic               b_zero;

   logic [2*WIDTH-1:0] prod;
   logic [WIDTH-1:0]   quo;
   logic [WIDTH-1:0]   rem;
   logic [WIDTH-1:0]   res_hi;
   logic [WIDTH-1:0]   res_lo;

   assign op_in  = op_t'(bus.op);
   assign a_neg  = op_is_signed(op_in) & bus.a[WIDTH-1];
   assign b_neg  = op_is_signed(op_in) & bus.b[WIDTH-1];
   assign mag_a  = a_neg ? -bus.a : bus.a;
   assign mag_b  = b_neg ? -bus.b : bus.b;
   assign b_zero = (bus.b == '0);

   muldiv_step #(
      .WIDTH (WIDTH)
   ) u_step (
      .is_div  (is_div_q),
      .acc_in  (acc_q),
      .sh_in   (sh_q),
      .opd_in  (opd_q),
      .acc_out (acc_nx),
      .sh_out  (sh_nx),
      .opd_out (opd_nx)
   );

`ifdef MULDIV_EARLY_EXIT_EN
   // A multiply is finished once no multiplier bits remain to be added in.
   assign calc_last = (cnt == CW'(WIDTH - 1)) || (!is_div_q && (opd_nx == '0));
`else
   assign calc_last = (cnt == CW'(WIDTH - 1));
`endif

   // FSM state register.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // FSM next state and datapath controls; flush always wins over progress.
   always_comb begin
      state_nxt  = state;
      launch     = 1'b0;
      step_en    = 1'b0;
      fin_commit = 1'b0;
      case (state)
         ST_IDLE: begin
            if (bus.start && !bus.flush) begin
               launch    = 1'b1;
               // Divide by zero has nothing to iterate.
               state_nxt = (op_is_div(op_in) && b_zero) ? ST_FIN : ST_CALC;
            end
         end
         ST_CALC: begin
            if (bus.flush) begin
               state_nxt = ST_IDLE;
            end else begin
               step_en = 1'b1;
               if (calc_last) begin
                  state_nxt = ST_FIN;
               end
            end
         end
         ST_FIN: begin
            state_nxt  = ST_IDLE;
            fin_commit = !bus.flush;
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   // Operand latching at launch and one iteration per CALC cycle.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         cnt        <= '0;
         is_div_q   <= 1'b0;
         div0_q     <= 1'b0;
         prod_neg_q <= 1'b0;
         rem_neg_q  <= 1'b0;
         acc_q      <= '0;
         sh_q       <= '0;
         opd_q      <= '0;
      end else if (launch) begin
         cnt        <= '0;
         is_div_q   <= op_is_div(op_in);
         div0_q     <= op_is_div(op_in) & b_zero;
         prod_neg_q <= a_neg ^ b_neg;
         rem_neg_q  <= a_neg;
         opd_q      <= mag_b;
         if (op_is_div(op_in)) begin
            acc_q <= {{WIDTH{1'b0}}, mag_a};
            sh_q  <= '0;
         end else begin
            acc_q <= '0;
            sh_q  <= {{WIDTH{1'b0}}, mag_a};
         end
      end else if (step_en) begin
         cnt   <= cnt + CW'(1);
         acc_q <= acc_nx;
         sh_q  <= sh_nx;
         opd_q <= opd_nx;
      end
   end

   // Sign correction of the magnitude result.
   always_comb begin
      prod   = prod_neg_q ? -acc_q : acc_q;
      quo    = acc_q[WIDTH-1:0];
      rem    = acc_q[2*WIDTH-1:WIDTH];
      res_hi = prod[2*WIDTH-1:WIDTH];
      res_lo = prod[WIDTH-1:0];
      if (is_div_q) begin
         res_lo = prod_neg_q ? -quo : quo;
         res_hi = rem_neg_q ? -rem : rem;
      end
   end

   // HI/LO: result write in FIN, otherwise MTHI/MTLO accepted only in IDLE.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         hi_q <= '0;
         lo_q <= '0;
      end else if (fin_commit && !div0_q) begin
         hi_q <= res_hi;
         lo_q <= res_lo;
      end else if (state == ST_IDLE) begin
         if (bus.hi_we) begin
            hi_q <= bus.wdata;
         end
         if (bus.lo_we) begin
            lo_q <= bus.wdata;
         end
      end
   end

   // Completion pulses, aligned with the cycle hi/lo become valid.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         done_q <= 1'b0;
         dbz_q  <= 1'b0;
      end else begin
         done_q <= fin_commit;
         dbz_q  <= fin_commit & div0_q;
      end
   end

   assign bus.busy        = (state != ST_IDLE);
   assign bus.done        = done_q;
   assign bus.div_by_zero = dbz_q;
   assign bus.hi          = hi_q;
   assign bus.lo          = lo_q;
   assign bus.dbg_state   = state;

endmodule

// File: doc/alu_muldiv.md
Name: alu_muldiv

Overview:
- Iterative multiply/divide unit that sits beside the single-cycle ALU in the EX stage.
- Executes MULT, MULTU, DIV and DIVU over multiple cycles with a start/busy/done handshake.
- Owns the architectural HI/LO registers, including the MTHI/MTLO write path.
- The pipeline stalls on busy and reads hi/lo directly.

Parameters:
- WIDTH, default 32: operand width; hi and lo are each WIDTH bits wide.

Ports:
- clk  input  1  rising-edge clock
- resetn  input  1  asynchronous active-low reset
- flush  input  1  abort the operation in flight (exception/ERET)
- start  input  1  launch an operation; sampled only in IDLE
- op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- a  input  WIDTH  multiplicand / dividend
- b  input  WIDTH  multiplier / divisor
- hi_we  input  1  MTHI write strobe
- lo_we  input  1  MTLO write strobe
- wdata  input  WIDTH  MTHI/MTLO data
- busy  output  1  operation in progress; pipeline stalls
- done  output  1  one-cycle pulse: hi/lo now hold the result
- div_by_zero  output  1  valid with done; set for DIV/DIVU with b==0
- hi  output  WIDTH  HI register
- lo  output  WIDTH  LO register

Behaviour:
- Reset (asynchronous, on resetn low, including mid-operation):
  - state returns to IDLE.
  - hi, lo, busy, done and div_by_zero all go to 0.
- State machine: IDLE -> CALC -> FIN -> IDLE.
- IDLE:
  - start=1 with flush=0 latches op and operand magnitudes, then goes to CALC. busy is high from the next cycle.
  - Signed ops take two's-complement magnitudes; result signs are latched at start.
- CALC:
  - One radix-2 step per cycle, WIDTH cycles total.
  - Multiply uses shift-add on a 2*WIDTH accumulator.
  - Divide uses restoring division, one quotient bit per cycle.
- FIN:
  - Applies the sign fix and writes hi/lo. done=1 and busy=0 in the following cycle, then IDLE.
  - With start in cycle 0, done is high in cycle WIDTH+2 and hi/lo are valid in that same cycle.
- Results:
  - Multiply: {hi,lo} = full 2*WIDTH product.
  - Divide: lo = quotient, hi = remainder. Quotient truncates toward zero; remainder takes the sign of the dividend.
  - Signed overflow (-2^(WIDTH-1) / -1): lo = 0x80000000, hi = 0. This is the natural wrap; no flag.
- Divide by zero:
  - Skips CALC; goes straight to FIN.
  - done=1 and div_by_zero=1 in cycle 2.
  - hi/lo are unchanged.
- start while busy: ignored. No queueing.
- flush:
  - In any non-IDLE state, returns to IDLE on the next edge.
  - hi/lo are unchanged and no done is produced.
  - flush and start in the same cycle: flush wins and start is dropped.
- hi_we / lo_we:
  - Honoured in IDLE only; ignored while busy (the pipeline guarantees the stall).
  - hi_we and start in the same IDLE cycle: the write lands first; the operation result overwrites it later.
- done and div_by_zero are single-cycle pulses and are 0 otherwise.

Optional Feature:
- Macro: MULDIV_EARLY_EXIT_EN
- Defined: in CALC, a multiply leaves for FIN as soon as the remaining shifted multiplier bits are all zero.
  - Latency becomes variable: the minimum is done in cycle 3 for b==0 or b==1.
  - Results are identical; divide is unaffected.
- Undefined: fixed WIDTH-cycle CALC for every op. The early-exit compare logic is absent.

Decomposition:
- Shared package muldiv_pkg holds:
  - op encodings MD_MULT, MD_MULTU, MD_DIV, MD_DIVU;
  - state encodings ST_IDLE, ST_CALC, ST_FIN;
  - the step-counter width, clog2(WIDTH+1).
- One combinational sub-module, muldiv_step, performs a single shift-add or restore-subtract step on {acc, operand}, selected by a mul/div input.
- The top module keeps the FSM, counter, sign handling and HI/LO registers.

Test Plan (all with WIDTH=32):
- MULTU a=0xFFFFFFFF b=0xFFFFFFFF, start cycle 0 -> done cycle 34, hi=0xFFFFFFFE, lo=0x00000001, busy high for cycles 1-33.
- MULT a=0xFFFFFFFD (-3) b=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1. MULT 0x80000000*0x80000000 -> hi=0x40000000, lo=0.
- DIV a=-7 b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU a=7 b=2 -> lo=3, hi=1. DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- MTHI 0x1234 then DIVU b=0 -> done and div_by_zero in cycle 2, hi=0x1234, lo unchanged.
- Reset/flush mid-operation:
  - flush in cycle 10 of MULTU -> busy low from cycle 11, no done, hi/lo keep old values; a second start in cycle 9 is ignored.
  - resetn low mid-CALC -> hi=lo=0 immediately.
- With MULDIV_EARLY_EXIT_EN: MULTU a=9 b=1 -> done cycle 3, lo=9, hi=0. Without it -> done cycle 34, same result.
